// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 20-bit words from a synchronous ROM and holds each
// one on instr_out for its class-specific number of cycles, stopping on HALT or stop.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | one cycle waiting on ROM latency for word 0
// RUN    | instruction held on instr_out, next word prefetched at pc+1
// HALTED | stopped on HALT word or stop request, waiting for start
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter int CNT_WIDTH   = 8,
    parameter int HOLD_STD    = 3,
    parameter int HOLD_LOAD   = 4,
    parameter int HOLD_STORE  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [INSTR_WIDTH-1:0] instr_rdata,
    output logic [PC_BITS-1:0]     instr_addr,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_BITS-1:0]     pc,
    output logic                   issue,
    output logic                   busy,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   retired
);

    localparam int HB = 4;

    typedef enum logic [1:0] {IDLE, FETCH, RUN, HALTED} state_t;

    state_t                 state, state_nx;
    logic [PC_BITS-1:0]     pc_nx, pc_inc;
    logic [INSTR_WIDTH-1:0] instr_nx;
    logic                   issue_nx;
    logic [CNT_WIDTH-1:0]   retired_nx;
    logic [HB-1:0]          hold, hold_nx;
    logic                   first, first_nx;
    logic                   stop_pend, stop_pend_nx;
    logic [1:0]             rd_class;

    assign rd_class = instr_rdata[INSTR_WIDTH-1 -: 2];
    assign pc_inc   = pc + PC_BITS'(1);
    assign busy     = (state == FETCH) || (state == RUN);
    assign halted   = (state == HALTED);

    function automatic logic [HB-1:0] hold_init(input logic [1:0] cls, input logic bonus);
        logic [HB-1:0] n;
        case (cls)
            2'b01:   n = HB'(HOLD_STD);
            2'b10:   n = HB'(HOLD_LOAD);
            2'b11:   n = HB'(HOLD_STORE);
            default: n = HB'(1);
        endcase
        return n - HB'(1) + HB'(bonus);
    endfunction

    // Presenting address 0 while start is being sampled lets the ROM return
    // word 0 exactly at the FETCH edge, even when restarting from a nonzero pc.
    always_comb begin
        instr_addr = pc;
        case (state)
            RUN:         instr_addr = pc_inc;
            IDLE, HALTED: if (start) instr_addr = '0;
            default:     instr_addr = pc;
        endcase
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        instr_nx     = instr_out;
        issue_nx     = 1'b0;
        retired_nx   = retired;
        hold_nx      = hold;
        first_nx     = first;
        stop_pend_nx = stop_pend;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nx     = FETCH;
                    pc_nx        = '0;
                    retired_nx   = '0;
                    stop_pend_nx = 1'b0;
                    first_nx     = 1'b1;
                end
            end
            FETCH: begin
                if (stop || rd_class == 2'b00) begin
                    state_nx = HALTED;
                    instr_nx = '0;
                end else begin
                    state_nx = RUN;
                    instr_nx = instr_rdata;
                    issue_nx = 1'b1;
                    hold_nx  = hold_init(rd_class, first);
                    first_nx = 1'b0;
                end
            end
            RUN: begin
                if (hold != '0) begin
                    hold_nx = hold - HB'(1);
                    if (stop) stop_pend_nx = 1'b1;
                end else begin
                    retired_nx = retired + CNT_WIDTH'(1);
                    if (stop_pend || stop) begin
                        state_nx = HALTED;
                        instr_nx = '0;
                    end else if (rd_class == 2'b00) begin
                        state_nx = HALTED;
                        instr_nx = '0;
                        pc_nx    = pc_inc;
                    end else begin
                        pc_nx    = pc_inc;
                        instr_nx = instr_rdata;
                        issue_nx = 1'b1;
                        hold_nx  = hold_init(rd_class, 1'b0);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= '0;
            instr_out <= '0;
            issue     <= 1'b0;
            retired   <= '0;
            hold      <= '0;
            first     <= 1'b1;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            instr_out <= instr_nx;
            issue     <= issue_nx;
            retired   <= retired_nx;
            hold      <= hold_nx;
            first     <= first_nx;
            stop_pend <= stop_pend_nx;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected issue/halt
// events with their cycle offsets from the start edge; a monitor pops and compares.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [19:0] instr_rdata;
    logic [4:0]  instr_addr;
    logic [19:0] instr_out;
    logic [4:0]  pc;
    logic        issue, busy, halted;
    logic [7:0]  retired;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .instr_rdata(instr_rdata), .instr_addr(instr_addr), .instr_out(instr_out),
        .pc(pc), .issue(issue), .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [19:0] rom [32];
    always @(posedge clk) instr_rdata <= rom[instr_addr];

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_halt;
        logic [19:0] word;
        logic [4:0]  pc;
        logic [7:0]  ret;
        int          off;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle offset %0d)", nm, act, exp, cyc - start_cyc);
        end
    endtask

    task automatic push_issue(input logic [19:0] w, input int p, input int r, input int off);
        ev_t e;
        e.is_halt = 1'b0; e.word = w; e.pc = 5'(p); e.ret = 8'(r); e.off = off;
        exp_q.push_back(e);
    endtask

    task automatic push_halt(input int p, input int r, input int off);
        ev_t e;
        e.is_halt = 1'b1; e.word = '0; e.pc = 5'(p); e.ret = 8'(r); e.off = off;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input bit is_halt);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_%s: no event expected (cycle offset %0d, pc %0d)",
                     is_halt ? "halt" : "issue", cyc - start_cyc, pc);
        end else begin
            e = exp_q.pop_front();
            chk(is_halt ? "halt_kind" : "issue_kind", 32'(is_halt), 32'(e.is_halt));
            chk("event_offset", 32'(cyc - start_cyc), 32'(e.off));
            chk("instr_out", 32'(instr_out), 32'(e.word));
            chk("pc", 32'(pc), 32'(e.pc));
            chk("retired", 32'(retired), 32'(e.ret));
            chk("instr_addr", 32'(instr_addr), is_halt ? 32'(e.pc) : 32'(5'(e.pc + 5'd1)));
            chk("busy", 32'(busy), 32'(!is_halt));
        end
    endtask

    logic halted_q = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (issue) check_event(1'b0);
            if (halted && !halted_q) check_event(1'b1);
        end
        halted_q = halted;
    end

    task automatic do_start(input bit keep);
        start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_to(input int off);
        while ((cyc - start_cyc) < off) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("halt_within_budget", 32'(halted), 32'd1);
        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) rom[i] = 20'h0_0000;
        rom[0] = 20'h4_1230;
        rom[1] = 20'h8_0050;
        rom[2] = 20'hC_0050;
        rom[3] = 20'h0_0000;
    endtask

    task automatic exp_prog();
        push_issue(20'h4_1230, 0, 0, 1);
        push_issue(20'h8_0050, 1, 1, 5);
        push_issue(20'hC_0050, 2, 2, 9);
        push_halt(3, 3, 12);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_instr_out"}, 32'(instr_out), 32'd0);
        chk({tag, "_instr_addr"}, 32'(instr_addr), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_issue"}, 32'(issue), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        load_prog();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // four-word program ending on HALT
        exp_prog();
        do_start(1'b0);
        wait_halt(40);

        // stop in the 2nd cycle of the load hold; store never issues
        push_issue(20'h4_1230, 0, 0, 1);
        push_issue(20'h8_0050, 1, 1, 5);
        push_halt(1, 2, 9);
        do_start(1'b0);
        wait_to(6);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_halt(40);

        // HALT at address 0
        rom[0] = 20'h0_0000;
        push_halt(0, 0, 1);
        do_start(1'b0);
        wait_halt(10);
        chk("halt0_instr_out", 32'(instr_out), 32'd0);

        // start held high through RUN is ignored, then a fresh restart
        load_prog();
        exp_prog();
        do_start(1'b1);
        wait_to(11);
        start = 1'b0;
        wait_halt(20);
        exp_prog();
        do_start(1'b0);
        wait_halt(40);

        // reset during the load hold
        push_issue(20'h4_1230, 0, 0, 1);
        push_issue(20'h8_0050, 1, 1, 5);
        do_start(1'b0);
        wait_to(6);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_reset_outputs("midrun_reset");
        chk("midrun_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("idle_after_reset_busy", 32'(busy), 32'd0);

        // 32 std words: pc/addr wrap and retired wrap past 255
        for (int i = 0; i < 32; i++) rom[i] = 20'h4_0000 | 20'(i);
        for (int k = 0; k < 258; k++)
            push_issue(20'h4_0000 | 20'(k % 32), k % 32, k % 256, (k == 0) ? 1 : 5 + 3 * (k - 1));
        push_halt(1, 2, 776);
        do_start(1'b0);
        wait_to(773);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_halt(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
